// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_tap_sequencer
//  Purpose  : Control and datapath stage wrapped around the FIR upcounter.
//             Accepts one sample per valid/ready handshake and stores it in a
//             circular history. It then walks the external 14-bit upcounter
//             through NTAPS tap indices. For each tap it addresses the
//             coefficient ROM, runs one multiply-accumulate, and presents one
//             filtered result on a valid/ready output.
//  Ports    : CLK, RESET_N (synchronous, active-low)
//             IN_VALID / IN_READY / IN_DATA      sample input handshake
//             CNT_LOAD / CNT_ENABLE / COUNT      upcounter control and index
//             COEF_ADDR / COEF_IN                coefficient ROM (1-cycle read)
//             OUT_VALID / OUT_READY / OUT_DATA   result output handshake
//             ERR                                sticky COUNT-out-of-range flag
//  Options  : FIR_ROUND_SAT_EN - round-half-up and saturate the output;
//             when undefined the output is truncated and wraps.
//  Revision : 1.0  initial release
// ============================================================================
module fir_tap_sequencer #(
    parameter int NTAPS = 16,
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int FRAC  = 15,
    parameter int CNTW  = 14
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [DW-1:0]   IN_DATA,
    output logic            CNT_LOAD,
    output logic            CNT_ENABLE,
    input  logic [CNTW-1:0] COUNT,
    output logic [AW-1:0]   COEF_ADDR,
    input  logic [CW-1:0]   COEF_IN,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [DW-1:0]   OUT_DATA,
    output logic            ERR
);

    localparam int ACCW = DW + CW + AW;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_run   = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_out   = 3'd4;

    localparam logic [CNTW-1:0] c_cnt_last = CNTW'(NTAPS - 1);

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic signed [DW-1:0]   r_hist [NTAPS];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_newest;
    logic signed [DW-1:0]   r_tap;
    logic                   r_mac_en;
    logic signed [ACCW-1:0] r_acc;
    logic [DW-1:0]          r_out_data;
    logic                   r_err;

    logic                     w_accept;
    logic [AW-1:0]            w_k;
    logic [AW-1:0]            w_rd_addr;
    logic                     w_count_oob;
    logic signed [CW-1:0]     w_coef;
    logic signed [DW+CW-1:0]  w_prod;
    logic signed [ACCW-1:0]   w_prod_ext;
    logic signed [ACCW-1:0]   w_acc_nxt;
    logic [DW-1:0]            w_scaled;

    assign w_accept  = (r_state == c_st_idle) && IN_VALID;
    assign w_k       = COUNT[AW-1:0];
    // Newest sample pairs with tap 0, older samples with higher taps.
    assign w_rd_addr = r_newest - w_k;
    // Compare against the last valid index so NTAPS == 2^CNTW cannot alias.
    assign w_count_oob = (COUNT > c_cnt_last);

    // r_tap was registered in the same cycle the ROM registered its
    // coefficient, so the two operands line up here.
    assign w_coef     = COEF_IN;
    assign w_prod     = r_tap * w_coef;
    assign w_prod_ext = {{AW{w_prod[DW+CW-1]}}, w_prod};
    assign w_acc_nxt  = r_mac_en ? (r_acc + w_prod_ext) : r_acc;

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [ACCW-1:0] c_rnd_half = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0] c_sat_max  =
        {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_sat_min  =
        {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [ACCW-1:0] w_rnd;
    logic signed [ACCW-1:0] w_shr;

    assign w_rnd = w_acc_nxt + c_rnd_half;
    assign w_shr = w_rnd >>> FRAC;

    always_comb begin
        w_scaled = w_shr[DW-1:0];
        if (w_shr > c_sat_max) begin
            w_scaled = c_sat_max[DW-1:0];
        end else if (w_shr < c_sat_min) begin
            w_scaled = c_sat_min[DW-1:0];
        end
    end
`else
    // Plain bit-select: floor toward minus infinity, wraps on overflow.
    assign w_scaled = w_acc_nxt[DW+FRAC-1:FRAC];
`endif

    // Next-state and Moore outputs.
    always_comb begin
        w_state_nxt = r_state;
        IN_READY    = 1'b0;
        CNT_LOAD    = 1'b0;
        CNT_ENABLE  = 1'b0;
        COEF_ADDR   = '0;
        OUT_VALID   = 1'b0;
        case (r_state)
            c_st_idle: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    w_state_nxt = c_st_load;
                end
            end
            c_st_load: begin
                CNT_LOAD    = 1'b1;
                w_state_nxt = c_st_run;
            end
            c_st_run: begin
                CNT_ENABLE = 1'b1;
                COEF_ADDR  = w_k;
                // An out-of-range COUNT also ends the run so the FSM cannot
                // hang on a faulty counter.
                if (COUNT >= c_cnt_last) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                w_state_nxt = c_st_out;
            end
            c_st_out: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= c_st_idle;
            r_wr_ptr   <= '0;
            r_newest   <= '0;
            r_tap      <= '0;
            r_mac_en   <= 1'b0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            // The MAC for a RUN cycle happens one cycle later, which makes
            // DRAIN perform the final tap.
            r_mac_en <= (r_state == c_st_run);
            r_tap    <= r_hist[w_rd_addr];

            if (w_accept) begin
                r_hist[r_wr_ptr] <= IN_DATA;
                r_newest         <= r_wr_ptr;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end

            if (r_state == c_st_load) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_nxt;
            end

            // Capture the result with the final MAC folded in, so OUT_DATA
            // stays stable for the whole OUT state.
            if (r_state == c_st_drain) begin
                r_out_data <= w_scaled;
            end

            if ((r_state == c_st_run) && w_count_oob) begin
                r_err <= 1'b1;
            end
        end
    end

    assign OUT_DATA = r_out_data;
    assign ERR      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_tap_sequencer
//  Purpose  : Self-checking bench for fir_tap_sequencer. It models the
//             external upcounter and a 1-cycle coefficient ROM, and compares
//             every result against a convolution reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_tap_sequencer;

    localparam int NTAPS = 16;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int FRAC  = 15;
    localparam int CNTW  = 14;
    localparam int TMO   = 200;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic            IN_VALID;
    logic            IN_READY;
    logic [DW-1:0]   IN_DATA;
    logic            CNT_LOAD;
    logic            CNT_ENABLE;
    logic [CNTW-1:0] COUNT;
    logic [AW-1:0]   COEF_ADDR;
    logic [CW-1:0]   COEF_IN;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [DW-1:0]   OUT_DATA;
    logic            ERR;

    always #5 CLK = ~CLK;

    fir_tap_sequencer #(
        .NTAPS(NTAPS), .AW(AW), .DW(DW), .CW(CW), .FRAC(FRAC), .CNTW(CNTW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .CNT_LOAD(CNT_LOAD), .CNT_ENABLE(CNT_ENABLE), .COUNT(COUNT),
        .COEF_ADDR(COEF_ADDR), .COEF_IN(COEF_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .ERR(ERR)
    );

    // External upcounter, with an override used to inject a counter fault.
    logic [CNTW-1:0] cnt_reg = '0;
    logic            cnt_force;
    logic [CNTW-1:0] cnt_force_val;
    assign COUNT = cnt_force ? cnt_force_val : cnt_reg;
    always @(posedge CLK) begin
        if (CNT_LOAD)        cnt_reg <= '0;
        else if (CNT_ENABLE) cnt_reg <= cnt_reg + 1'b1;
    end

    // Coefficient ROM, one cycle read latency.
    logic [CW-1:0] coef_rom [NTAPS];
    always @(posedge CLK) COEF_IN <= coef_rom[COEF_ADDR];

    // Activity monitors, sampled mid-cycle.
    int n_load, n_en, n_busy;
    always @(negedge CLK) begin
        if (CNT_LOAD)    n_load++;
        if (CNT_ENABLE)  n_en++;
        if (!IN_READY)   n_busy++;
    end

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the newest sample is at index 0 and pairs with
    // coefficient 0.
    int q[$];

    function automatic void model_push(input logic [DW-1:0] x);
        q.push_front(int'($signed(x)));
        if (q.size() > NTAPS) void'(q.pop_back());
    endfunction

    function automatic logic [DW-1:0] model_out();
        longint acc = 0;
        longint r;
        for (int k = 0; k < q.size(); k++)
            acc += longint'($signed(coef_rom[k])) * longint'(q[k]);
`ifdef FIR_ROUND_SAT_EN
        r = (acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`else
        r = acc >>> FRAC;
`endif
        return r[DW-1:0];
    endfunction

    task automatic apply_reset();
        RESET_N   = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        cnt_force = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        q.delete();
    endtask

    // Drives one sample through. lat counts the edges between the accept
    // edge and the first sampled OUT_VALID. The output is then held for
    // 'stall' cycles before it is taken.
    task automatic run_sample(input logic [DW-1:0] x, input int stall,
                              output logic [DW-1:0] y, output int lat,
                              output bit ok);
        int w = 0;
        ok = 1'b1;
        while (IN_READY !== 1'b1 && w < TMO) begin @(posedge CLK); #1; w++; end
        if (w >= TMO) ok = 1'b0;
        IN_DATA   = x;
        IN_VALID  = 1'b1;
        OUT_READY = (stall == 0);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 0;
        while (OUT_VALID !== 1'b1 && lat < TMO) begin @(posedge CLK); #1; lat++; end
        if (lat >= TMO) ok = 1'b0;
        y = OUT_DATA;
        repeat (stall) begin @(posedge CLK); #1; end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || CNT_LOAD !== 1'b0 ||
            CNT_ENABLE !== 1'b0 || ERR !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy=%b ov=%b ld=%b en=%b err=%b required 1 0 0 0 0",
                     IN_READY, OUT_VALID, CNT_LOAD, CNT_ENABLE, ERR);
        end
        n_checks++;
        if (OUT_DATA !== '0 || COEF_ADDR !== '0) begin
            n_err++;
            $display("FAIL reset_data: got out=%h addr=%h required 0 0", OUT_DATA, COEF_ADDR);
        end
    endtask

    task automatic test_latency();
        logic [DW-1:0] y; int lat; bit ok;
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = '0;
        coef_rom[0] = 16'h7FFF;
        apply_reset();
        n_load = 0; n_en = 0; n_busy = 0;
        run_sample(16'd1234, 0, y, lat, ok);
        model_push(16'd1234);
        n_checks++;
        if (!ok) begin n_err++; $display("FAIL lat_timeout: got timeout required completion"); end
        n_checks++;
        if (lat != NTAPS + 2) begin
            n_err++; $display("FAIL lat_cycles: got %0d required %0d", lat, NTAPS + 2);
        end
        n_checks++;
`ifdef FIR_ROUND_SAT_EN
        if (y !== 16'd1234) begin n_err++; $display("FAIL lat_data: got %0d required 1234", $signed(y)); end
`else
        if (y !== 16'd1233) begin n_err++; $display("FAIL lat_data: got %0d required 1233", $signed(y)); end
`endif
        n_checks++;
        if (n_busy != NTAPS + 3) begin
            n_err++; $display("FAIL lat_in_ready_low: got %0d cycles required %0d", n_busy, NTAPS + 3);
        end
        n_checks++;
        if (n_load != 1 || n_en != NTAPS) begin
            n_err++; $display("FAIL lat_counter_ctrl: got load=%0d en=%0d required 1 %0d", n_load, n_en, NTAPS);
        end
    endtask

    task automatic test_impulse();
        logic [DW-1:0] y, x; int lat; bit ok;
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = CW'(k * 1024);
        apply_reset();
        n_load = 0; n_en = 0;
        for (int i = 0; i < NTAPS; i++) begin
            x = (i == 0) ? 16'h7FFF : 16'h0000;
            run_sample(x, 0, y, lat, ok);
            model_push(x);
            n_checks++;
            if (!ok || y !== model_out()) begin
                n_err++; $display("FAIL impulse_out%0d: got %0d required %0d (ok=%0b)", i, $signed(y), $signed(model_out()), ok);
            end
        end
        n_checks++;
        if (n_load != NTAPS || n_en != NTAPS * NTAPS) begin
            n_err++; $display("FAIL impulse_counter_ctrl: got load=%0d en=%0d required %0d %0d",
                              n_load, n_en, NTAPS, NTAPS * NTAPS);
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] y; int lat; bit ok;
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'h7FFF;
        apply_reset();
        for (int i = 0; i < NTAPS; i++) begin
            run_sample(16'h7FFF, 0, y, lat, ok);
            model_push(16'h7FFF);
            n_checks++;
            if (!ok || y !== model_out()) begin
                n_err++; $display("FAIL sat_out%0d: got %h required %h", i, y, model_out());
            end
        end
        n_checks++;
`ifdef FIR_ROUND_SAT_EN
        if (y !== 16'h7FFF) begin n_err++; $display("FAIL sat_final: got %h required 7fff", y); end
`else
        if (y !== 16'hFFE0) begin n_err++; $display("FAIL sat_final: got %h required ffe0", y); end
`endif
    endtask

    task automatic test_stall();
        logic [DW-1:0] y, y0, xa, xb; int lat, w; bit ok;
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'($urandom);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            xa = 16'($urandom);
            run_sample(xa, 0, y, lat, ok);
            model_push(xa);
        end
        xa = 16'($urandom);
        xb = 16'($urandom);
        IN_DATA = xa; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        w = 0;
        while (OUT_VALID !== 1'b1 && w < TMO) begin @(posedge CLK); #1; w++; end
        y0 = OUT_DATA;
        model_push(xa);
        n_checks++;
        if (w >= TMO || y0 !== model_out()) begin
            n_err++; $display("FAIL stall_first_out: got %h required %h (wait=%0d)", y0, model_out(), w);
        end
        IN_DATA = xb; IN_VALID = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            n_checks++;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== y0 || IN_READY !== 1'b0) begin
                n_err++; $display("FAIL stall_hold%0d: got ov=%b out=%h rdy=%b required 1 %h 0",
                                  c, OUT_VALID, OUT_DATA, IN_READY, y0);
            end
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if (IN_READY !== 1'b1) begin n_err++; $display("FAIL stall_idle_after_handshake: got rdy=%b required 1", IN_READY); end
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        n_checks++;
        if (IN_READY !== 1'b0) begin n_err++; $display("FAIL stall_accept_next: got rdy=%b required 0", IN_READY); end
        model_push(xb);
        lat = 0;
        while (OUT_VALID !== 1'b1 && lat < TMO) begin @(posedge CLK); #1; lat++; end
        y = OUT_DATA;
        n_checks++;
        if (lat != NTAPS + 2 || y !== model_out()) begin
            n_err++; $display("FAIL stall_second_out: got %h lat=%0d required %h lat=%0d", y, lat, model_out(), NTAPS + 2);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_counter_fault();
        logic [DW-1:0] y, x; int lat, w; bit ok;
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'($urandom);
        apply_reset();
        x = 16'($urandom);
        IN_DATA = x; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        model_push(x);
        w = 0;
        while (!(CNT_ENABLE === 1'b1 && COUNT == 14'd3) && w < TMO) begin @(posedge CLK); #1; w++; end
        cnt_force_val = 14'd20;
        cnt_force     = 1'b1;
        @(posedge CLK); #1;
        cnt_force = 1'b0;
        n_checks++;
        if (w >= TMO || ERR !== 1'b1 || CNT_ENABLE !== 1'b0) begin
            n_err++; $display("FAIL fault_err_set: got err=%b en=%b required 1 0", ERR, CNT_ENABLE);
        end
        w = 0;
        while (OUT_VALID !== 1'b1 && w < TMO) begin @(posedge CLK); #1; w++; end
        n_checks++;
        if (w >= TMO) begin n_err++; $display("FAIL fault_reach_out: got timeout required OUT_VALID"); end
        @(posedge CLK); #1;
        n_checks++;
        if (IN_READY !== 1'b1 || ERR !== 1'b1) begin
            n_err++; $display("FAIL fault_handshake: got rdy=%b err=%b required 1 1", IN_READY, ERR);
        end
        x = 16'($urandom);
        run_sample(x, 0, y, lat, ok);
        model_push(x);
        n_checks++;
        if (!ok || y !== model_out() || ERR !== 1'b1) begin
            n_err++; $display("FAIL fault_after: got %h err=%b required %h err=1", y, ERR, model_out());
        end
    endtask

    task automatic test_reset_midrun();
        logic [DW-1:0] y; int lat, w; bit ok;
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = '0;
        coef_rom[0] = 16'h7FFF;
        coef_rom[1] = 16'h4000;
        // ERR is still set from the fault test; history is non-zero.
        run_sample(16'd5000, 0, y, lat, ok);
        IN_DATA = 16'd777; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        w = 0;
        while (!(CNT_ENABLE === 1'b1 && COUNT == 14'd7) && w < TMO) begin @(posedge CLK); #1; w++; end
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        q.delete();
        n_checks++;
        if (w >= TMO || IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || OUT_DATA !== '0 ||
            CNT_LOAD !== 1'b0 || CNT_ENABLE !== 1'b0 || COEF_ADDR !== '0 || ERR !== 1'b0) begin
            n_err++; $display("FAIL midrun_reset_outputs: got rdy=%b ov=%b out=%h ld=%b en=%b addr=%h err=%b required 1 0 0 0 0 0 0",
                              IN_READY, OUT_VALID, OUT_DATA, CNT_LOAD, CNT_ENABLE, COEF_ADDR, ERR);
        end
        run_sample(16'd100, 0, y, lat, ok);
        model_push(16'd100);
        n_checks++;
        if (!ok || y !== model_out()) begin
            n_err++; $display("FAIL midrun_model: got %0d required %0d", $signed(y), $signed(model_out()));
        end
        n_checks++;
`ifdef FIR_ROUND_SAT_EN
        if (y !== 16'd100) begin n_err++; $display("FAIL midrun_value: got %0d required 100", $signed(y)); end
`else
        if (y !== 16'd99) begin n_err++; $display("FAIL midrun_value: got %0d required 99", $signed(y)); end
`endif
    endtask

    task automatic test_random();
        logic [DW-1:0] y, x; int lat; bit ok;
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'($urandom);
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            run_sample(x, int'($urandom_range(0, 3)), y, lat, ok);
            model_push(x);
            n_checks++;
            if (!ok || lat != NTAPS + 2 || y !== model_out()) begin
                n_err++; $display("FAIL random%0d: got %h lat=%0d required %h lat=%0d",
                                  i, y, lat, model_out(), NTAPS + 2);
            end
        end
    endtask

    initial begin
        RESET_N       = 1'b0;
        IN_VALID      = 1'b0;
        IN_DATA       = '0;
        OUT_READY     = 1'b1;
        cnt_force     = 1'b0;
        cnt_force_val = '0;
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = '0;
        @(posedge CLK); #1;
        test_reset();
        test_latency();
        test_impulse();
        test_saturation();
        test_stall();
        test_counter_fault();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
